// File: rtl/usbf_sie_tx_sched_pkg.sv
// Shared PID byte constants and handshake request codes for the SIE transmit path.
package usbf_sie_tx_sched_pkg;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    localparam logic [1:0] HS_ACK   = 2'b00;
    localparam logic [1:0] HS_NAK   = 2'b01;
    localparam logic [1:0] HS_STALL = 2'b10;

    // The reserved code 2'b11 is sent as STALL.
    function automatic logic [7:0] hs_pid(input logic [1:0] code);
        case (code)
            HS_ACK:  return PID_ACK;
            HS_NAK:  return PID_NAK;
            default: return PID_STALL;
        endcase
    endfunction

endpackage

// File: rtl/usbf_sie_tx_sched_if.sv
// Request, endpoint-FIFO and SIE handshake signals around the tx scheduler.
interface usbf_sie_tx_sched_if #(
    parameter int LEN_W = 11
);
    logic             enable_i;
    logic             hs_req_i;
    logic [1:0]       hs_code_i;
    logic             data_req_i;
    logic             data_toggle_i;
    logic [LEN_W-1:0] data_len_i;
    logic             req_ack_o;
    logic [LEN_W-1:0] fifo_level_i;
    logic             fifo_valid_i;
    logic [7:0]       fifo_data_i;
    logic             fifo_pop_o;
    logic             tx_valid_o;
    logic [7:0]       tx_pid_o;
    logic             tx_accept_i;
    logic             data_valid_o;
    logic             data_strb_o;
    logic [7:0]       data_o;
    logic             data_last_o;
    logic             data_accept_i;
    logic             done_o;
    logic             abort_o;
    logic             busy_o;

    // master: the scheduler itself; slave: protocol logic, FIFO and SIE.
    modport master (
        input  enable_i, hs_req_i, hs_code_i, data_req_i, data_toggle_i, data_len_i,
               fifo_level_i, fifo_valid_i, fifo_data_i, tx_accept_i, data_accept_i,
        output req_ack_o, fifo_pop_o, tx_valid_o, tx_pid_o, data_valid_o, data_strb_o,
               data_o, data_last_o, done_o, abort_o, busy_o
    );

    modport slave (
        output enable_i, hs_req_i, hs_code_i, data_req_i, data_toggle_i, data_len_i,
               fifo_level_i, fifo_valid_i, fifo_data_i, tx_accept_i, data_accept_i,
        input  req_ack_o, fifo_pop_o, tx_valid_o, tx_pid_o, data_valid_o, data_strb_o,
               data_o, data_last_o, done_o, abort_o, busy_o
    );
endinterface

// File: rtl/usbf_sie_tx_sched.sv
// Store-and-forward transmit scheduler: sequences handshake and data packets
// (PID then payload from a FWFT FIFO) into the SIE transmitter.
module usbf_sie_tx_sched
    import usbf_sie_tx_sched_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    usbf_sie_tx_sched_if.master bus
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_PID, S_DATA, S_WAIT_IDLE} state_t;

    state_t           state, state_nxt;
    logic             is_hs, is_hs_nxt;
    logic [1:0]       code, code_nxt;
    logic             toggle, toggle_nxt;
    logic             zlp, zlp_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;

    logic       req_ack, pop, tx_valid, data_valid, data_strb, data_last, done, abort;
    logic [7:0] tx_pid, data;
    logic       drive_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            is_hs     <= 1'b0;
            code      <= 2'b00;
            toggle    <= 1'b0;
            zlp       <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            is_hs     <= is_hs_nxt;
            code      <= code_nxt;
            toggle    <= toggle_nxt;
            zlp       <= zlp_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        is_hs_nxt     = is_hs;
        code_nxt      = code;
        toggle_nxt    = toggle;
        zlp_nxt       = zlp;
        remaining_nxt = remaining;
        req_ack       = 1'b0;
        pop           = 1'b0;
        tx_valid      = 1'b0;
        tx_pid        = 8'h00;
        data_valid    = 1'b0;
        data_strb     = 1'b0;
        data_last     = 1'b0;
        data          = 8'h00;
        done          = 1'b0;
        abort         = 1'b0;

        // Payload lines are already presented during PID so the SIE sees the
        // ZLP marker in the same cycle it accepts the PID.
        drive_data = (state == S_PID) || (state == S_DATA);
        if (drive_data && bus.enable_i) begin
            if (zlp) begin
                data_valid = 1'b1;
                data_last  = 1'b1;
            end else begin
                data_valid = bus.fifo_valid_i;
                data_strb  = 1'b1;
                data       = bus.fifo_data_i;
                data_last  = (remaining == LEN_W'(1));
            end
        end

        case (state)
            S_IDLE: begin
                if (bus.enable_i) begin
                    if (bus.hs_req_i) begin
                        req_ack   = 1'b1;
                        is_hs_nxt = 1'b1;
                        code_nxt  = bus.hs_code_i;
                        state_nxt = S_PID;
                    end else if (bus.data_req_i) begin
                        req_ack       = 1'b1;
                        is_hs_nxt     = 1'b0;
                        toggle_nxt    = bus.data_toggle_i;
                        remaining_nxt = bus.data_len_i;
                        zlp_nxt       = (bus.data_len_i == '0);
                        state_nxt     = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (zlp || (bus.fifo_level_i >= remaining))
                    state_nxt = S_PID;
            end
            S_PID: begin
                tx_valid = 1'b1;
                tx_pid   = is_hs ? hs_pid(code) : (toggle ? PID_DATA1 : PID_DATA0);
                if (bus.tx_accept_i)
                    state_nxt = is_hs ? S_WAIT_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bus.data_accept_i && data_valid) begin
                    pop = !zlp;
                    if (remaining != '0)
                        remaining_nxt = remaining - LEN_W'(1);
                    if (data_last)
                        state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (bus.tx_accept_i) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Disable wins over everything: drop the SIE handshakes in this cycle.
        if (!bus.enable_i && state != S_IDLE) begin
            state_nxt     = S_IDLE;
            remaining_nxt = remaining;
            abort         = 1'b1;
            tx_valid      = 1'b0;
            data_valid    = 1'b0;
            pop           = 1'b0;
            done          = 1'b0;
        end
    end

    assign bus.req_ack_o    = req_ack;
    assign bus.fifo_pop_o   = pop;
    assign bus.tx_valid_o   = tx_valid;
    assign bus.tx_pid_o     = tx_pid;
    assign bus.data_valid_o = data_valid;
    assign bus.data_strb_o  = data_strb;
    assign bus.data_o       = data;
    assign bus.data_last_o  = data_last;
    assign bus.done_o       = done;
    assign bus.abort_o      = abort;
    assign bus.busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_usbf_sie_tx_sched.sv
// Directed bench for the SIE tx scheduler with a small FWFT FIFO model.
module tb_usbf_sie_tx_sched;

    localparam int LEN_W = 11;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   pop_cnt = 0;
    int   done_cnt = 0;
    int   abort_cnt = 0;
    logic [7:0] fifo_q[$];
    logic pop_s;

    usbf_sie_tx_sched_if #(.LEN_W(LEN_W)) bus ();

    usbf_sie_tx_sched #(.LEN_W(LEN_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void fifo_refresh();
        bus.fifo_level_i = LEN_W'(fifo_q.size());
        bus.fifo_valid_i = (fifo_q.size() > 0);
        bus.fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_refresh();
    endtask

    // Count pulses at the edge, then apply the pop just after it.
    always @(posedge clk) begin
        pop_s = bus.fifo_pop_o;
        if (bus.fifo_pop_o) pop_cnt++;
        if (bus.done_o)     done_cnt++;
        if (bus.abort_o)    abort_cnt++;
        #1;
        if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_refresh();
    end

    task automatic step();
        @(negedge clk);
    endtask

    int p0, d0, a0;

    initial begin
        rst = 1'b1;
        bus.enable_i = 1'b0;
        bus.hs_req_i = 1'b0;
        bus.hs_code_i = 2'b00;
        bus.data_req_i = 1'b0;
        bus.data_toggle_i = 1'b0;
        bus.data_len_i = '0;
        bus.tx_accept_i = 1'b0;
        bus.data_accept_i = 1'b0;
        fifo_refresh();

        // Reset state
        step(); step();
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_tx_valid", bus.tx_valid_o, 0);
        chk("rst_data_valid", bus.data_valid_o, 0);
        chk("rst_pid", bus.tx_pid_o, 0);
        rst = 1'b0;

        // Disabled: request must not be acked
        step();
        bus.hs_req_i = 1'b1;
        #1 chk("dis_no_ack", bus.req_ack_o, 0);
        step();
        bus.enable_i = 1'b1;

        // Handshake ACK
        #1 chk("ack_req_ack", bus.req_ack_o, 1);
        step();
        bus.hs_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ack_tx_valid_hold", bus.tx_valid_o, 1);
            chk("ack_pid", bus.tx_pid_o, 8'hD2);
            step();
        end
        bus.tx_accept_i = 1'b1;
        #1 chk("ack_tx_valid_acc", bus.tx_valid_o, 1);
        step();
        bus.tx_accept_i = 1'b0;
        #1;
        chk("ack_wait_busy", bus.busy_o, 1);
        chk("ack_wait_no_done", bus.done_o, 0);
        step();
        bus.tx_accept_i = 1'b1;
        #1 chk("ack_done", bus.done_o, 1);
        step();
        bus.tx_accept_i = 1'b0;
        #1;
        chk("ack_idle", bus.busy_o, 0);
        chk("ack_done_cnt", done_cnt, 1);
        chk("ack_pop_cnt", pop_cnt, 0);

        // DATA1, 3 bytes
        p0 = pop_cnt; d0 = done_cnt;
        push(8'hA1); push(8'hA2); push(8'hA3);
        bus.data_req_i = 1'b1; bus.data_toggle_i = 1'b1; bus.data_len_i = 11'd3;
        #1 chk("d3_ack", bus.req_ack_o, 1);
        step();
        bus.data_req_i = 1'b0;
        #1;
        chk("d3_fill_busy", bus.busy_o, 1);
        chk("d3_fill_no_tx", bus.tx_valid_o, 0);
        step();
        #1;
        chk("d3_tx_valid", bus.tx_valid_o, 1);
        chk("d3_pid", bus.tx_pid_o, 8'h4B);
        chk("d3_pid_data", bus.data_o, 8'hA1);
        chk("d3_pid_last", bus.data_last_o, 0);
        bus.tx_accept_i = 1'b1;
        step();
        bus.tx_accept_i = 1'b0;
        #1;
        chk("d3_stall_valid", bus.data_valid_o, 1);
        chk("d3_stall_data", bus.data_o, 8'hA1);
        step();
        #1 chk("d3_stall_pop", pop_cnt, p0);
        bus.data_accept_i = 1'b1;
        #1;
        chk("d3_b1", bus.data_o, 8'hA1);
        chk("d3_b1_strb", bus.data_strb_o, 1);
        chk("d3_b1_last", bus.data_last_o, 0);
        chk("d3_b1_pop", bus.fifo_pop_o, 1);
        step();
        #1;
        chk("d3_b2", bus.data_o, 8'hA2);
        chk("d3_b2_last", bus.data_last_o, 0);
        step();
        #1;
        chk("d3_b3", bus.data_o, 8'hA3);
        chk("d3_b3_last", bus.data_last_o, 1);
        step();
        bus.data_accept_i = 1'b0;
        #1;
        chk("d3_pop_cnt", pop_cnt - p0, 3);
        chk("d3_wait_no_data", bus.data_valid_o, 0);
        bus.tx_accept_i = 1'b1;
        #1 chk("d3_done", bus.done_o, 1);
        step();
        bus.tx_accept_i = 1'b0;
        #1 chk("d3_done_cnt", done_cnt - d0, 1);

        // DATA0 ZLP
        p0 = pop_cnt; d0 = done_cnt;
        bus.data_req_i = 1'b1; bus.data_toggle_i = 1'b0; bus.data_len_i = 11'd0;
        #1 chk("zlp_ack", bus.req_ack_o, 1);
        step();
        bus.data_req_i = 1'b0;
        step();
        #1;
        chk("zlp_pid", bus.tx_pid_o, 8'hC3);
        chk("zlp_dvalid", bus.data_valid_o, 1);
        chk("zlp_strb", bus.data_strb_o, 0);
        chk("zlp_last", bus.data_last_o, 1);
        chk("zlp_data", bus.data_o, 0);
        bus.tx_accept_i = 1'b1;
        step();
        bus.tx_accept_i = 1'b0; bus.data_accept_i = 1'b1;
        #1 chk("zlp_no_pop", bus.fifo_pop_o, 0);
        step();
        bus.data_accept_i = 1'b0;
        #1 chk("zlp_wait_no_done", bus.done_o, 0);
        bus.tx_accept_i = 1'b1;
        #1 chk("zlp_done", bus.done_o, 1);
        step();
        bus.tx_accept_i = 1'b0;
        #1 chk("zlp_pop_cnt", pop_cnt - p0, 0);

        // Store-and-forward: wait for full payload
        d0 = done_cnt;
        push(8'h11); push(8'h22);
        bus.data_req_i = 1'b1; bus.data_len_i = 11'd4;
        #1 chk("sf_ack", bus.req_ack_o, 1);
        step();
        bus.data_req_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("sf_no_tx", bus.tx_valid_o, 0);
            chk("sf_busy", bus.busy_o, 1);
            step();
        end
        push(8'h33); push(8'h44);
        #1 chk("sf_still_fill", bus.tx_valid_o, 0);
        step();
        #1 chk("sf_tx_valid", bus.tx_valid_o, 1);
        bus.tx_accept_i = 1'b1;
        step();
        bus.tx_accept_i = 1'b0; bus.data_accept_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("sf_last", bus.data_last_o, (i == 3) ? 1 : 0);
            step();
        end
        bus.data_accept_i = 1'b0; bus.tx_accept_i = 1'b1;
        #1 chk("sf_done", bus.done_o, 1);
        step();
        bus.tx_accept_i = 1'b0;

        // Simultaneous requests: handshake wins, data waits for done
        push(8'h55);
        bus.hs_req_i = 1'b1; bus.hs_code_i = 2'b01;
        bus.data_req_i = 1'b1; bus.data_toggle_i = 1'b0; bus.data_len_i = 11'd1;
        #1 chk("pri_ack", bus.req_ack_o, 1);
        step();
        bus.hs_req_i = 1'b0;
        #1;
        chk("pri_pid_nak", bus.tx_pid_o, 8'h5A);
        chk("pri_no_ack_pid", bus.req_ack_o, 0);
        bus.tx_accept_i = 1'b1;
        step();
        #1;
        chk("pri_done", bus.done_o, 1);
        chk("pri_no_ack_wait", bus.req_ack_o, 0);
        step();
        bus.tx_accept_i = 1'b0;
        #1 chk("pri_data_ack", bus.req_ack_o, 1);
        step();
        bus.data_req_i = 1'b0;
        step();
        #1 chk("pri_pid_d0", bus.tx_pid_o, 8'hC3);
        bus.tx_accept_i = 1'b1;
        step();
        bus.tx_accept_i = 1'b0; bus.data_accept_i = 1'b1;
        #1;
        chk("pri_byte", bus.data_o, 8'h55);
        chk("pri_last", bus.data_last_o, 1);
        step();
        bus.data_accept_i = 1'b0; bus.tx_accept_i = 1'b1;
        #1 chk("pri_done2", bus.done_o, 1);
        step();
        bus.tx_accept_i = 1'b0;

        // Reserved code sent as STALL
        bus.hs_req_i = 1'b1; bus.hs_code_i = 2'b11;
        step();
        bus.hs_req_i = 1'b0;
        #1 chk("rsv_pid", bus.tx_pid_o, 8'h1E);
        bus.tx_accept_i = 1'b1;
        step(); step();
        bus.tx_accept_i = 1'b0;

        // Abort after 2 of 5 bytes
        p0 = pop_cnt; d0 = done_cnt; a0 = abort_cnt;
        for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
        bus.data_req_i = 1'b1; bus.data_len_i = 11'd5;
        step();
        bus.data_req_i = 1'b0;
        step();
        bus.tx_accept_i = 1'b1;
        step();
        bus.tx_accept_i = 1'b0; bus.data_accept_i = 1'b1;
        step(); step();
        bus.data_accept_i = 1'b0; bus.enable_i = 1'b0;
        #1;
        chk("ab_tx_valid", bus.tx_valid_o, 0);
        chk("ab_data_valid", bus.data_valid_o, 0);
        chk("ab_abort", bus.abort_o, 1);
        step();
        #1;
        chk("ab_busy", bus.busy_o, 0);
        chk("ab_abort_cnt", abort_cnt - a0, 1);
        chk("ab_no_done", done_cnt - d0, 0);
        chk("ab_pops", pop_cnt - p0, 2);
        bus.enable_i = 1'b1;
        fifo_q.delete();
        fifo_refresh();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
